// File: rtl/legv8_defs_pkg.sv
// Shared LEGv8 fetch definitions: PC-select codes, fetch FSM state codes, HLT encoding and bus widths.
package legv8_defs_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_REG    = 2'b10;

    localparam logic [INSTR_W-1:0] HLT_ENC = 32'hD440_0000;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_HALT  = 2'd2,
        IF_FAULT = 2'd3
    } if_state_t;

endpackage

// File: rtl/legv8_imem.sv
// Instruction memory: one sync write port, one sync read port (read-before-write on a shared address).
// The read register also records whether the word read equals MATCH_WORD, and clears synchronously.
module legv8_imem
    import legv8_defs_pkg::*;
#(
    parameter int                 WORDS      = 256,
    parameter logic [INSTR_W-1:0] MATCH_WORD = HLT_ENC,
    localparam int                AW         = $clog2(WORDS)
) (
    input  logic               clock,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               rd_clr,
    input  logic               rd_en,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata,
    output logic               rmatch
);

    logic [INSTR_W-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_clr) begin
            rdata  <= '0;
            rmatch <= 1'b0;
        end else if (rd_en) begin
            rdata  <= mem[raddr];
            rmatch <= (mem[raddr] == MATCH_WORD);
        end
    end

endmodule

// File: rtl/legv8_instruction_fetch.sv
// LEGv8 fetch stage: PC register, next-PC select, BOOT/RUN/HALT/FAULT FSM; one cycle advance-to-instruction.
// Optional perf counters under IFETCH_PERF_CNT_EN; holds all outputs while advance is low.
module legv8_instruction_fetch
    import legv8_defs_pkg::*;
#(
    parameter int                 IMEM_WORDS = 256,
    parameter logic [INSTR_W-1:0] HALT_WORD  = HLT_ENC,
    localparam int                AW         = $clog2(IMEM_WORDS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               advance,
    input  logic [1:0]         pc_sel,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid,
    output logic               halted,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count,
`endif
    output logic               fault
);

    if_state_t         state;
    logic [ADDR_W-1:0] next_pc;
    logic              legal;
    logic              take;
    logic              fetch_ok;
    logic [AW-1:0]     rd_addr;

    assign pc_plus4 = pc + 64'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            PC_SEL_BRANCH: next_pc = pc + (branch_offset << 2);
            PC_SEL_REG:    next_pc = br_target;
            default:       next_pc = pc_plus4;
        endcase
    end

    assign legal    = (next_pc[1:0] == 2'b00) && (next_pc[ADDR_W-1:AW+2] == '0);
    assign take     = (state == IF_RUN) && advance && !halted;
    assign fetch_ok = (state == IF_BOOT) || (take && legal);
    assign rd_addr  = (state == IF_BOOT) ? '0 : next_pc[AW+1:2];

    legv8_imem #(
        .WORDS      (IMEM_WORDS),
        .MATCH_WORD (HALT_WORD)
    ) u_imem (
        .clock  (clock),
        .we     (prog_we),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .rd_clr (reset),
        .rd_en  (fetch_ok),
        .raddr  (rd_addr),
        .rdata  (instruction),
        .rmatch (halted)
    );

    // halted is registered with the fetched word, so a HALT word stops fetch from the
    // same edge it is loaded; the state code catches up one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IF_BOOT;
            pc          <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IF_BOOT: begin
                    pc          <= '0;
                    instr_valid <= 1'b1;
                    state       <= IF_RUN;
                end
                IF_RUN: begin
                    if (halted) begin
                        state <= IF_HALT;
                    end else if (advance) begin
                        pc <= next_pc;
                        if (!legal) begin
                            state       <= IF_FAULT;
                            fault       <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic redirect_ok;
    assign redirect_ok = take && legal &&
                         ((pc_sel == PC_SEL_BRANCH) || (pc_sel == PC_SEL_REG));

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (fetch_ok && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_ok && (redirect_count != 32'hFFFF_FFFF)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule
